tick_timer: RTL and testbench
=============================

# tick_timer

Loadable down-counting timer that consumes the one-cycle carry strobe produced by the team's prescaler counters (the mod-N `cout` style generators) and turns a programmed number of strobes into a single-cycle `done` event. It sits on the consumer side of the prescaler strobe interface. It is the correct-practice replacement for gated or derived clocks: everything runs on the system clock, and the strobe is used only as a clock enable.

## Interface
- `W`, 16, width of the tick count and the load value.
- `clk` input 1: system clock; all flops are rising-edge.
- `rstn` input 1: **reset is asynchronous and active-low**; single clock domain.
- `tick_i` input 1: prescaler strobe; each cycle it is high counts as one tick.
- `load_valid` input 1: load request.
- `load_ready` output 1: timer can accept a load; high only in IDLE.
- `load_value` input W: tick count N; sampled on a load handshake.
- `reload_i` input 1: periodic mode request; sampled with `load_value` (only with `TICK_TIMER_RELOAD_EN`).
- `pause_i` input 1: level input; freezes counting while high.
- `abort_i` input 1: single-cycle request; returns the timer to IDLE.
- `busy` output 1: timer is in RUN or PAUSE.
- `count` output W: remaining ticks.
- `done` output 1: one-cycle pulse at expiry.
- `err` output 1: one-cycle pulse when a zero load is accepted.

## Operation
- **States:** IDLE, RUN, PAUSE.
- **Handshake:** a load is accepted on a rising edge where `load_valid && load_ready`.
  - Effect: `count <= load_value`, the period register is loaded, and the reload flag is latched.
  - Next state is RUN.
  - `load_valid` may stay high; while the timer is not in IDLE it is simply not accepted.
- **Zero load:** accepted; `err` pulses the next cycle; state stays IDLE; `count` stays 0.
- **RUN, tick with `count > 1`:** `count` decrements by 1.
- **RUN, tick with `count == 1` (expiry):**
  - `done` pulses on the following cycle.
  - One-shot: `count` becomes 0 and the state goes to IDLE.
  - Reload: `count` becomes the period and the state stays RUN.
- **RUN → PAUSE:** when `pause_i` is high. Ticks arriving while paused are dropped, not queued.
- **PAUSE → RUN:** when `pause_i` is low.
- **Abort:** `abort_i` in RUN or PAUSE sends the state to IDLE and sets `count` to 0, with no `done`. In IDLE it has no effect.
- **Priority (highest first):** abort, pause, tick.
  - Tick together with abort: no `done`.
  - Tick together with pause: the tick is dropped.
- **Load cycle:** a tick in the same cycle as load acceptance is ignored. The first tick counted is the one in the next cycle.
- **Arithmetic:** unsigned; `count` never wraps below 0. N = 2^W−1 is legal. A load of N produces `done` after exactly N counted ticks.

## Timing
- **Reset values:** state IDLE; `load_ready` 1; `busy` 0; `count` 0; `done` 0; `err` 0; period 0; reload flag 0.
- **Reset mid-operation:** immediate return to reset values; any pending `done` is lost.
- **Registered outputs:** `count`, `done` and `err` are registered. `load_ready` and `busy` are decoded from the state register.
- **Latency:**
  - `done` is high in the cycle after the edge that sampled the Nth tick.
  - The cycle after a one-shot expiry, `load_ready` is 1, so a back-to-back load is possible with zero idle cycles.
- **Reload mode:** `done` period equals N ticks exactly; the reload cycle loses no tick.
- **Tick rate:** `tick_i` high on consecutive cycles is legal; every cycle counts.

## Configuration
- Macro: `TICK_TIMER_RELOAD_EN`.
- **Defined:** `reload_i` exists and periodic mode works as described above.
- **Undefined:**
  - `reload_i` is not present.
  - The timer is one-shot only: every expiry goes to IDLE.
  - No period register is built; `count` alone holds the state.

## Structure
- Package `tick_timer_pkg`:
  - state enum `tick_timer_state_e` (IDLE, RUN, PAUSE);
  - default width constant `TICK_TIMER_W = 16`.
- Sub-module `tick_timer_cnt`:
  - W-bit loadable down-counter with enable;
  - `is_one` flag output and synchronous clear.
- Top level: FSM, handshake, priority logic and the `done`/`err` registers.
- The sequential block that owns each register is the only one that assigns it. `clk` is never gated, compared or combined with logic.

## Test plan
- **One-shot:** load 3; `tick_i` every 4th cycle → `count` 3→2→1→0. `done` is high exactly 1 cycle after the 3rd tick; then `load_ready`=1 and `busy`=0.
- **Zero load:** load 0 → `err`=1 for one cycle; state stays IDLE; `done` never asserts.
- **Abort with tick:** load 2, one tick (`count`=1), then `abort_i` and `tick_i` in the same cycle → `count`=0, IDLE, no `done`.
- **Pause:** load 2, `pause_i` high for 10 cycles with 3 ticks during it → `count` stays 2. After release, 2 more ticks → `done`.
- **Reload (macro defined):** load 2 with `reload_i`=1 and `tick_i` tied high → `done` every 2nd cycle and `count` alternates 2,1,2,1.
- **Reset mid-run:** load 5, after 2 ticks drop `rstn` asynchronously between clock edges → all outputs at reset values immediately. After release, load 1 plus one tick → `done`.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick_timer slice.
// Optional periodic mode is enabled by defining TICK_TIMER_RELOAD_EN.
package tick_timer_pkg;

    localparam int TICK_TIMER_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } tick_timer_state_e;

endpackage

// File: rtl/tick_timer_if.sv
// Load/strobe/status bundle between a controller (master) and the timer (slave).
// reload_i exists only when TICK_TIMER_RELOAD_EN is defined.
interface tick_timer_if
    import tick_timer_pkg::*;
#(
    parameter int W = TICK_TIMER_W
);

    logic         tick_i;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
`ifdef TICK_TIMER_RELOAD_EN
    logic         reload_i;
`endif
    logic         pause_i;
    logic         abort_i;
    logic         busy;
    logic [W-1:0] count;
    logic         done;
    logic         err;

    modport master (
        output tick_i,
        output load_valid,
        output load_value,
`ifdef TICK_TIMER_RELOAD_EN
        output reload_i,
`endif
        output pause_i,
        output abort_i,
        input  load_ready,
        input  busy,
        input  count,
        input  done,
        input  err
    );

    modport slave (
        input  tick_i,
        input  load_valid,
        input  load_value,
`ifdef TICK_TIMER_RELOAD_EN
        input  reload_i,
`endif
        input  pause_i,
        input  abort_i,
        output load_ready,
        output busy,
        output count,
        output done,
        output err
    );

endinterface

// File: rtl/tick_timer_cnt.sv
// W-bit loadable down-counter with enable, synchronous clear and an is-one flag.
// Priority is clear, then load, then decrement; decrement saturates at zero.
module tick_timer_cnt
    import tick_timer_pkg::*;
#(
    parameter int W = TICK_TIMER_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_is_one
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_is_one = (r_count == W'(1));

endmodule

// File: rtl/tick_timer.sv
// Down-counting timer that turns N prescaler strobes into a one-cycle done pulse.
// Periodic (reload) mode is built only when TICK_TIMER_RELOAD_EN is defined.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int W = TICK_TIMER_W
) (
    input  logic         clk,
    input  logic         rstn,
    tick_timer_if.slave  bus
);

    tick_timer_state_e r_state;
    tick_timer_state_e w_next_state;

    logic         w_clr;
    logic         w_load;
    logic         w_dec;
    logic [W-1:0] w_load_val;
    logic         w_done_nxt;
    logic         w_err_nxt;
    logic [W-1:0] w_count;
    logic         w_is_one;
    logic         r_done;
    logic         r_err;

`ifdef TICK_TIMER_RELOAD_EN
    logic [W-1:0] r_period;
    logic         r_reload;
    logic         w_accept;

    assign w_accept = (r_state == IDLE) && bus.load_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_period <= '0;
            r_reload <= 1'b0;
        end else if (w_accept) begin
            r_period <= bus.load_value;
            r_reload <= bus.reload_i;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Abort beats pause beats tick; a paused cycle drops its tick.
    always_comb begin
        w_next_state = r_state;
        w_clr        = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_load_val   = bus.load_value;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load_valid) begin
                    w_load = 1'b1;
                    if (bus.load_value == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_next_state = RUN;
                    end
                end
            end
            RUN, PAUSE: begin
                if (bus.abort_i) begin
                    w_clr        = 1'b1;
                    w_next_state = IDLE;
                end else if (bus.pause_i) begin
                    w_next_state = PAUSE;
                end else begin
                    w_next_state = RUN;
                    if (bus.tick_i) begin
                        if (w_is_one) begin
                            w_done_nxt = 1'b1;
`ifdef TICK_TIMER_RELOAD_EN
                            if (r_reload) begin
                                w_load     = 1'b1;
                                w_load_val = r_period;
                            end else begin
                                w_clr        = 1'b1;
                                w_next_state = IDLE;
                            end
`else
                            w_clr        = 1'b1;
                            w_next_state = IDLE;
`endif
                        end else begin
                            w_dec = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_clr        = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    tick_timer_cnt #(
        .W (W)
    ) u_cnt (
        .clk          (clk),
        .rstn         (rstn),
        .i_clr        (w_clr),
        .i_load       (w_load),
        .i_load_value (w_load_val),
        .i_en         (w_dec),
        .o_count      (w_count),
        .o_is_one     (w_is_one)
    );

    assign bus.load_ready = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.count      = w_count;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_tick_timer.sv
// Directed, table-driven bench for tick_timer; reload rows run only with TICK_TIMER_RELOAD_EN.
module tb_tick_timer;

    localparam int W = 16;

    typedef struct {
        string        name;
        logic         tick;
        logic         lv;
        logic [W-1:0] val;
        logic         rl;
        logic         pause;
        logic         abort;
        logic [W-1:0] expCount;
        logic         expDone;
        logic         expErr;
        logic         expReady;
        logic         expBusy;
    } vec_t;

    logic clk;
    logic rstn;
    int   checks;
    int   fails;
    vec_t vecs[$];

    tick_timer_if #(.W(W)) bus ();

    tick_timer #(.W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic tk, logic lv, logic [W-1:0] val, logic rl,
                                logic ps, logic ab, logic [W-1:0] c, logic d, logic e,
                                logic rdy, logic bsy);
        vec_t v;
        v.name = n; v.tick = tk; v.lv = lv; v.val = val; v.rl = rl; v.pause = ps;
        v.abort = ab; v.expCount = c; v.expDone = d; v.expErr = e; v.expReady = rdy;
        v.expBusy = bsy;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(string name, logic [W-1:0] c, logic d, logic e, logic rdy, logic bsy);
        checkOutput({name, ".count"}, 32'(bus.count), 32'(c));
        checkOutput({name, ".done"}, 32'(bus.done), 32'(d));
        checkOutput({name, ".err"}, 32'(bus.err), 32'(e));
        checkOutput({name, ".load_ready"}, 32'(bus.load_ready), 32'(rdy));
        checkOutput({name, ".busy"}, 32'(bus.busy), 32'(bsy));
    endtask

    task automatic driveIdle();
        bus.tick_i     = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_value = '0;
        bus.pause_i    = 1'b0;
        bus.abort_i    = 1'b0;
`ifdef TICK_TIMER_RELOAD_EN
        bus.reload_i   = 1'b0;
`endif
    endtask

    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        bus.tick_i     = v.tick;
        bus.load_valid = v.lv;
        bus.load_value = v.val;
        bus.pause_i    = v.pause;
        bus.abort_i    = v.abort;
`ifdef TICK_TIMER_RELOAD_EN
        bus.reload_i   = v.rl;
`endif
        @(posedge clk);
        #1;
        checkAll(v.name, v.expCount, v.expDone, v.expErr, v.expReady, v.expBusy);
    endtask

    task automatic asyncResetPulse(string name);
        @(negedge clk);
        driveIdle();
        #2 rstn = 1'b0;
        #1 checkAll(name, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 rstn = 1'b1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rstn   = 1'b0;
        driveIdle();
        #12;
        checkAll("reset", '0, 1'b0, 1'b0, 1'b1, 1'b0);
        rstn = 1'b1;

        // one-shot: load 3, tick every 4th cycle
        vecs.push_back(mk("os_load", 0, 1, 3, 0, 0, 0, 3, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++)
                vecs.push_back(mk("os_wait", 0, 0, 0, 0, 0, 0, W'(3 - k), 0, 0, 0, 1));
            if (k < 2)
                vecs.push_back(mk("os_tick", 1, 0, 0, 0, 0, 0, W'(2 - k), 0, 0, 0, 1));
        end
        vecs.push_back(mk("os_expire", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("os_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // zero load
        vecs.push_back(mk("zero_load", 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk("zero_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // abort with tick
        vecs.push_back(mk("ab_load", 0, 1, 2, 0, 0, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk("ab_tick", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("ab_abort", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("ab_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("ab_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        // pause: 10 cycles, ticks on 3 of them are dropped
        vecs.push_back(mk("ps_load", 0, 1, 2, 0, 0, 0, 2, 0, 0, 0, 1));
        for (int j = 0; j < 10; j++)
            vecs.push_back(mk("ps_hold", (j % 3) == 2, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk("ps_release", 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk("ps_tick1", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("ps_tick2", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // tick on load cycle ignored; back-to-back load; held load_valid not accepted while busy
        vecs.push_back(mk("bb_load1", 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("bb_exp1", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("bb_load2", 0, 1, 2, 0, 0, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk("bb_hold1", 1, 1, 7, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("bb_hold2", 1, 1, 7, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("bb_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // maximum load value
        vecs.push_back(mk("max_load", 0, 1, 16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 0, 1));
        vecs.push_back(mk("max_tick", 1, 0, 0, 0, 0, 0, 16'hFFFE, 0, 0, 0, 1));
        vecs.push_back(mk("max_pause_abort", 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // asynchronous reset in the middle of a run
        applyStimulus(mk("rst_load", 0, 1, 5, 0, 0, 0, 5, 0, 0, 0, 1));
        applyStimulus(mk("rst_tick1", 1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1));
        applyStimulus(mk("rst_tick2", 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1));
        asyncResetPulse("rst_midrun");
        applyStimulus(mk("rst_reload1", 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        applyStimulus(mk("rst_retick", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        // done that is still high is dropped by reset
        asyncResetPulse("rst_done_lost");
        applyStimulus(mk("rst_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

`ifdef TICK_TIMER_RELOAD_EN
        applyStimulus(mk("rl_load", 1, 1, 2, 1, 0, 0, 2, 0, 0, 0, 1));
        for (int j = 0; j < 6; j++)
            applyStimulus(mk("rl_run", 1, 0, 0, 0, 0, 0, (j % 2) == 0 ? W'(1) : W'(2),
                             (j % 2) == 1, 0, 0, 1));
        applyStimulus(mk("rl_abort", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        applyStimulus(mk("rl_oneshot", 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1));
        applyStimulus(mk("rl_oneshot_exp", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
`endif

        @(negedge clk);
        driveIdle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
